// File: rtl/stream_burst_ctrl.sv
// Burst sequencer: gates an AXI-Stream source into framed bursts
// with tlast, programmable idle gaps and a completion pulse.
module stream_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8,
    parameter int GAP_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              aresetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              abort,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              s_tready,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  bursts_sent
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP,
        DONE
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [GAP_W-1:0]   gap_q;
    logic [CNT_W-1:0]   count_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic [CNT_W-1:0]   burst_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [CNT_W-1:0]   bursts_sent_q;
    logic               aborted_q;
    logic               abort_pend_q;

    logic in_burst;
    logic xfer;
    logic last_beat;
    logic final_burst;
    logic abort_now;

    assign in_burst    = (state_q == BURST);
    assign last_beat   = (beat_cnt_q == len_q - LEN_W'(1));
    assign final_burst = (burst_cnt_q == count_q - CNT_W'(1));
    assign abort_now   = abort | abort_pend_q;

    // Ready never looks at s_tvalid, so no combinational ready/valid loop.
    assign s_tready = in_burst & m_tready;
    assign m_tvalid = in_burst & s_tvalid;
    assign m_tdata  = s_tdata;
    assign m_tlast  = last_beat & m_tvalid;
    assign xfer     = m_tvalid & m_tready;

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = in_burst | (state_q == GAP);
    assign done        = (state_q == DONE);
    assign aborted     = aborted_q;
    assign bursts_sent = bursts_sent_q;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            len_q         <= '0;
            gap_q         <= '0;
            count_q       <= '0;
            beat_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            bursts_sent_q <= '0;
            aborted_q     <= 1'b0;
            abort_pend_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        len_q         <= cfg_len;
                        gap_q         <= cfg_gap;
                        count_q       <= cfg_count;
                        beat_cnt_q    <= '0;
                        burst_cnt_q   <= '0;
                        bursts_sent_q <= '0;
                        aborted_q     <= 1'b0;
                        abort_pend_q  <= 1'b0;
                        if (cfg_len == '0 || cfg_count == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    // A burst in flight always runs to its tlast beat.
                    if (xfer) begin
                        if (last_beat) begin
                            beat_cnt_q    <= '0;
                            bursts_sent_q <= bursts_sent_q + CNT_W'(1);
                            if (final_burst || abort_now) begin
                                state_q   <= DONE;
                                aborted_q <= abort_now;
                            end else begin
                                burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                                if (gap_q != '0) begin
                                    gap_cnt_q <= gap_q;
                                    state_q   <= GAP;
                                end
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (abort_now) begin
                        abort_pend_q <= 1'b1;
                        aborted_q    <= 1'b1;
                        state_q      <= DONE;
                    end else if (gap_cnt_q == GAP_W'(1)) begin
                        state_q <= BURST;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                DONE: begin
                    abort_pend_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/stream_burst_ctrl.md
# stream_burst_ctrl

Burst sequencer placed between a free-running AXI-Stream source (the 8-bit counter generator) and a downstream AXI-Stream sink. A one-shot command sets burst length, inter-burst gap and burst count. The block then gates the source's tready to cut the stream into framed bursts with tlast, idle gaps and a completion pulse. The datapath is a zero-latency pass-through; all sequencing lives in an FSM with beat, gap and burst counters.

## Interface
- DATA_W, 8, stream data width
- LEN_W, 8, width of burst-length field
- GAP_W, 8, width of gap field
- CNT_W, 16, width of burst-count field and burst status counter

- clock  in  1  single clock, rising edge
- aresetn  in  1  asynchronous, active-low reset
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accept; high only in IDLE
- cfg_len  in  LEN_W  beats per burst
- cfg_gap  in  GAP_W  idle cycles between bursts
- cfg_count  in  CNT_W  number of bursts
- abort  in  1  request early stop; level, sampled each cycle
- s_tvalid  in  1  source valid
- s_tdata  in  DATA_W  source data
- s_tready  out  1  source ready
- m_tvalid  out  1  sink valid
- m_tdata  out  DATA_W  sink data, equal to s_tdata
- m_tlast  out  1  last beat of burst
- m_tready  in  1  sink ready
- busy  out  1  high in BURST or GAP
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done; set when the run ended by abort
- bursts_sent  out  CNT_W  bursts completed in current or last run

## Operation
- FSM states: IDLE, BURST, GAP, DONE.
- IDLE: cfg_ready=1. On cfg_valid, latch len/gap/count, clear beat_cnt, burst_cnt, bursts_sent and aborted.
  - If len==0 or count==0, go to DONE. No beats are emitted.
  - Otherwise go to BURST.
- BURST:
  - s_tready = m_tready; m_tvalid = s_tvalid; m_tdata = s_tdata.
  - A beat is transferred when m_tvalid & m_tready. Each transfer increments beat_cnt.
  - m_tlast = (beat_cnt == len-1) & m_tvalid.
- On the last-beat transfer: bursts_sent++, beat_cnt clears, then:
  - If burst_cnt==count-1 or an abort is pending, go to DONE.
  - Else if gap==0, stay in BURST and increment burst_cnt.
  - Else load gap_cnt=gap, increment burst_cnt and go to GAP.
- GAP:
  - s_tready=0, m_tvalid=0, m_tlast=0.
  - gap_cnt decrements each cycle. At gap_cnt==1 go to BURST, giving exactly gap idle cycles.
  - If an abort is pending, go to DONE on the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE.
- Abort:
  - abort high in BURST or GAP sets abort_pending, which clears on entry to IDLE.
  - In BURST, the current burst always completes with tlast; packets are never truncated.
  - aborted=1 with done, held until the next command is accepted.
  - abort in IDLE or DONE is ignored.
- Outputs outside BURST: s_tready=0, m_tvalid=0.
- Counters compare at full width. len, gap and count use their whole range, e.g. len=255 gives 255 beats.
- Reset (async assert, sync deassert by the surrounding reset bridge):
  - state=IDLE, all counters 0.
  - m_tvalid=0, s_tready=0, m_tlast=0, busy=0, done=0, aborted=0, bursts_sent=0.
  - cfg_ready=1 after deassert. cfg_valid is ignored while aresetn is low.
- Reset mid-burst drops the run immediately. No done is emitted.

## Timing
- Datapath latency 0: m_tdata/m_tvalid are combinational from s_tdata/s_tvalid in BURST.
- s_tready depends only on state and m_tready. It never depends on s_tvalid (no ready-on-valid loop).
- State changes only on a handshake or on counter expiry. m_tvalid therefore never drops during a stalled beat while s_tvalid is held.
- Command accept to first possible beat: 1 cycle (BURST is entered on the edge after accept).
- Last beat of final burst to done: 1 cycle.
- Zero-length command: done on the cycle after accept.
- Next cfg_ready: the cycle after done.
- Gap: exactly cfg_gap cycles with m_tvalid=0 between the tlast handshake and the next beat.
- busy rises the cycle after accept and falls with entry to DONE.

## Test plan
- len=4, gap=2, count=3, counter source, m_tready=1 -> beats 0..3 (tlast on 3), 2 idle cycles, 4..7, 2 idle cycles, 8..11. done 1 cycle after beat 11, bursts_sent=3, aborted=0.
- Same config with m_tready toggling 1,0,1,0 -> m_tdata held during stalls, s_tready mirrors m_tready, no value lost or duplicated, 12 beats total.
- len=0, count=5 -> done on the cycle after accept, m_tvalid never high, bursts_sent=0. Same result for count=0.
- len=2, gap=0, count=3 -> 6 consecutive beats 0..5, tlast on beats 1, 3, 5, no idle cycles.
- len=8, count=4, abort pulsed during beat 3 of burst 0 -> beats 0..7 with tlast on 7, then done, aborted=1, bursts_sent=1. Abort during GAP -> done the cycle after, no further beats.
- aresetn low during beat 5 -> m_tvalid, s_tready, busy go 0 with no clock edge. After release: cfg_ready=1, no done, a new command runs normally.
